// File: rtl/tcb_lite_lib_multiplexer_rr_pkg.sv
// Shared types and helpers for the round-robin TCB-Lite multiplexer and its arbiter.
package tcb_lite_lib_multiplexer_rr_pkg;

  // Upper bound on the number of managers the round-robin search handles.
  localparam int unsigned MaxIfn = 32;
  localparam int unsigned MaxIdx = 5;
  localparam int unsigned IdxExt = MaxIdx + 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StLock
  } arb_state_e;

  // Index width that stays legal when only one manager is present.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First asserted vld at or after ptr, wrapping modulo ifn; ptr when none is set.
  function automatic logic [MaxIdx-1:0] rr_first(input logic [MaxIfn-1:0] vld,
                                                 input logic [MaxIdx-1:0] ptr,
                                                 input int unsigned       ifn);
    logic [IdxExt-1:0] idx;
    logic              found;
    rr_first = ptr;
    found    = 1'b0;
    for (int unsigned k = 0; k < MaxIfn; k++) begin
      idx = {1'b0, ptr} + IdxExt'(k);
      if (idx >= IdxExt'(ifn)) idx = idx - IdxExt'(ifn);
      if (!found && (k < ifn) && vld[idx[MaxIdx-1:0]]) begin
        rr_first = idx[MaxIdx-1:0];
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/tcb_lite_lib_multiplexer_rr_if.sv
// TCB-Lite handshake bundle: vld/rdy with per-field request and response signals.
interface tcb_lite_lib_multiplexer_rr_if #(
  parameter int unsigned DAT = 32,
  parameter int unsigned ADR = 32
) ();

  localparam int unsigned MSK = DAT / 8;

  logic           vld;
  logic           rdy;
  logic           req_lck;
  logic           req_wen;
  logic [ADR-1:0] req_adr;
  logic [MSK-1:0] req_byt;
  logic [DAT-1:0] req_wdt;
  logic [DAT-1:0] rsp_rdt;
  logic           rsp_err;

  modport man (
    output vld, req_lck, req_wen, req_adr, req_byt, req_wdt,
    input  rdy, rsp_rdt, rsp_err
  );

  modport sub (
    input  vld, req_lck, req_wen, req_adr, req_byt, req_wdt,
    output rdy, rsp_rdt, rsp_err
  );

endinterface

// File: rtl/tcb_lite_lib_multiplexer_rr_arbiter.sv
// Round-robin arbiter with IDLE/WAIT/LOCK grant freezing.
// LOCK is reachable only when TCB_LITE_LIB_MULTIPLEXER_LCK_EN is defined.
module tcb_lite_lib_multiplexer_rr_arbiter
  import tcb_lite_lib_multiplexer_rr_pkg::*;
#(
  parameter int unsigned IFN = 2,
  localparam int unsigned IFL = idx_width(IFN)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [IFN-1:0] vld_i,
  input  logic           rdy_i,
  input  logic           lck_i,
  output logic [IFL-1:0] gnt_o
);

  arb_state_e     state_q, state_d;
  logic [IFL-1:0] ptr_q, ptr_d;
  logic [IFL-1:0] gnt_q, gnt_d;
  logic [IFL-1:0] gnt_rr, gnt;
  logic           gnt_vld, trn, lck;

`ifdef TCB_LITE_LIB_MULTIPLEXER_LCK_EN
  assign lck = lck_i;
`else
  logic unused_lck;
  assign unused_lck = lck_i;
  assign lck        = 1'b0;
`endif

  assign gnt_rr = IFL'(rr_first(MaxIfn'(vld_i), MaxIdx'(ptr_q), IFN));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    gnt     = (state_q == StIdle) ? gnt_rr : gnt_q;
    gnt_vld = vld_i[gnt];
    trn     = gnt_vld & rdy_i;
    if (trn) ptr_d = (gnt == IFL'(IFN - 1)) ? '0 : gnt + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (trn && lck) begin
          state_d = StLock;
          gnt_d   = gnt;
        end else if (gnt_vld && !rdy_i) begin
          state_d = StWait;
          gnt_d   = gnt;
        end
      end
      StWait: begin
        // A stalled manager withdrawing its request is illegal; recover to free arbitration.
        if (!gnt_vld) state_d = StIdle;
        else if (trn) state_d = lck ? StLock : StIdle;
      end
`ifdef TCB_LITE_LIB_MULTIPLEXER_LCK_EN
      StLock: begin
        if (trn && !lck) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_o = rst_ni ? gnt : '0;

  always_ff @(posedge clk_i) begin
    if (rst_ni && (state_q == StWait)) begin
      assert (vld_i[gnt_q]) else $error("stalled manager dropped vld before its transfer");
    end
  end

endmodule

// File: rtl/tcb_lite_lib_multiplexer_rr.sv
// Round-robin multiplexer: IFN TCB-Lite managers share one manager port; responses broadcast.
// Define TCB_LITE_LIB_MULTIPLEXER_LCK_EN to honour req_lck (locked atomic sequences).
module tcb_lite_lib_multiplexer_rr
  import tcb_lite_lib_multiplexer_rr_pkg::*;
#(
  parameter int unsigned IFN = 2,
  parameter int unsigned DLY = 1,
  parameter int unsigned DAT = 32,
  parameter int unsigned ADR = 32,
  localparam int unsigned IFL = idx_width(IFN)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  tcb_lite_lib_multiplexer_rr_if.sub         sub [IFN-1:0],
  tcb_lite_lib_multiplexer_rr_if.man         man,
  output logic [IFL-1:0]                     gnt_o
);

  localparam int unsigned MSK = DAT / 8;

  logic [IFN-1:0] sub_vld, sub_lck, sub_wen;
  logic [ADR-1:0] sub_adr [IFN];
  logic [MSK-1:0] sub_byt [IFN];
  logic [DAT-1:0] sub_wdt [IFN];
  logic [IFL-1:0] gnt;
  logic           man_trn;

  for (genvar i = 0; i < IFN; i++) begin : g_sub
    assign sub_vld[i]     = sub[i].vld;
    assign sub_lck[i]     = sub[i].req_lck;
    assign sub_wen[i]     = sub[i].req_wen;
    assign sub_adr[i]     = sub[i].req_adr;
    assign sub_byt[i]     = sub[i].req_byt;
    assign sub_wdt[i]     = sub[i].req_wdt;
    assign sub[i].rdy     = rst_ni & man.rdy & (gnt == IFL'(i));
    // Every manager sees the response; only the one owning this slot samples it.
    assign sub[i].rsp_rdt = man.rsp_rdt;
    assign sub[i].rsp_err = man.rsp_err;
  end

  assign man.vld     = rst_ni & sub_vld[gnt];
  assign man.req_lck = sub_lck[gnt];
  assign man.req_wen = sub_wen[gnt];
  assign man.req_adr = sub_adr[gnt];
  assign man.req_byt = sub_byt[gnt];
  assign man.req_wdt = sub_wdt[gnt];
  assign man_trn     = man.vld & man.rdy;

  tcb_lite_lib_multiplexer_rr_arbiter #(
    .IFN (IFN)
  ) u_arbiter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .vld_i  (sub_vld),
    .rdy_i  (man.rdy),
    .lck_i  (sub_lck[gnt]),
    .gnt_o  (gnt)
  );

  assign gnt_o = gnt;

  if (DLY > 0) begin : g_pip
    logic [IFL-1:0] sel_pip_q [DLY];
    logic [DLY-1:0] trn_pip_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < DLY; k++) sel_pip_q[k] <= '0;
        trn_pip_q <= '0;
      end else begin
        sel_pip_q[0] <= man_trn ? gnt : '0;
        for (int k = 1; k < DLY; k++) sel_pip_q[k] <= sel_pip_q[k-1];
        trn_pip_q <= DLY'({trn_pip_q, man_trn});
      end
    end

    // The manager owning a response slot must be the one that issued that transfer.
    always_ff @(posedge clk_i) begin
      if (rst_ni && trn_pip_q[DLY-1]) begin
        assert (sel_pip_q[DLY-1] == $past(gnt, DLY))
          else $error("response slot owner differs from transfer issuer");
      end
    end
  end else begin : g_comb
    logic [IFL-1:0] unused_rsp_sel;
    assign unused_rsp_sel = gnt;
  end

endmodule

// File: tb/tb_tcb_lite_lib_multiplexer_rr.sv
// Randomized bench for the round-robin multiplexer against a queue-based arbitration model.
module tb_tcb_lite_lib_multiplexer_rr;

  localparam int unsigned IFN = 3;
  localparam int unsigned DLY = 2;
  localparam int unsigned DAT = 32;
  localparam int unsigned ADR = 32;
  localparam int unsigned IFL = 2;
  localparam int unsigned MSK = DAT / 8;

`ifdef TCB_LITE_LIB_MULTIPLEXER_LCK_EN
  localparam bit LckEn = 1'b1;
`else
  localparam bit LckEn = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [IFL-1:0] gnt_o;

  tcb_lite_lib_multiplexer_rr_if #(.DAT(DAT), .ADR(ADR)) sub_if [IFN-1:0] ();
  tcb_lite_lib_multiplexer_rr_if #(.DAT(DAT), .ADR(ADR)) man_if ();

  logic [IFN-1:0] drv_vld, drv_lck, drv_wen, obs_rdy, obs_err;
  logic [ADR-1:0] drv_adr [IFN];
  logic [MSK-1:0] drv_byt [IFN];
  logic [DAT-1:0] drv_wdt [IFN];
  logic [DAT-1:0] obs_rdt [IFN];
  logic           man_rdy, man_err;
  logic [DAT-1:0] man_rdt;

  for (genvar g = 0; g < IFN; g++) begin : g_mgr
    assign sub_if[g].vld     = drv_vld[g];
    assign sub_if[g].req_lck = drv_lck[g];
    assign sub_if[g].req_wen = drv_wen[g];
    assign sub_if[g].req_adr = drv_adr[g];
    assign sub_if[g].req_byt = drv_byt[g];
    assign sub_if[g].req_wdt = drv_wdt[g];
    assign obs_rdy[g]        = sub_if[g].rdy;
    assign obs_rdt[g]        = sub_if[g].rsp_rdt;
    assign obs_err[g]        = sub_if[g].rsp_err;
  end

  assign man_if.rdy     = man_rdy;
  assign man_if.rsp_rdt = man_rdt;
  assign man_if.rsp_err = man_err;

  tcb_lite_lib_multiplexer_rr #(
    .IFN (IFN),
    .DLY (DLY),
    .DAT (DAT),
    .ADR (ADR)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sub    (sub_if),
    .man    (man_if),
    .gnt_o  (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int             cyc;
    int             own;
    logic [DAT-1:0] rdt;
    logic           err;
  } rsp_t;

  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   m_ptr = 0;
  int   m_owner = -1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Owner if frozen, else first requester at or after the pointer, else the pointer.
  function automatic int model_gnt();
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < int'(IFN); k++) begin
      if (drv_vld[(m_ptr + k) % IFN]) return (m_ptr + k) % IFN;
    end
    return m_ptr;
  endfunction

  task automatic raise_req(input int i);
    drv_vld[i] = 1'b1;
    drv_lck[i] = ($urandom_range(3) == 0);
    drv_wen[i] = 1'($urandom);
    drv_adr[i] = $urandom;
    drv_byt[i] = MSK'($urandom);
    drv_wdt[i] = $urandom;
  endtask

  task automatic run_cycle(input int unsigned req_pct, input int unsigned rdy_pct);
    int             g;
    logic           v, trn;
    logic [IFN-1:0] exp_rdy;
    @(negedge clk_i);
    g       = model_gnt();
    v       = drv_vld[g];
    trn     = v & man_rdy;
    exp_rdy = '0;
    if (man_rdy) exp_rdy[g] = 1'b1;
    check_eq("gnt", gnt_o, g);
    check_eq("man_vld", man_if.vld, v);
    check_eq("man_adr", man_if.req_adr, drv_adr[g]);
    check_eq("man_wdt", man_if.req_wdt, drv_wdt[g]);
    check_eq("man_ctl", {man_if.req_byt, man_if.req_wen, man_if.req_lck},
             {drv_byt[g], drv_wen[g], drv_lck[g]});
    check_eq("sub_rdy", obs_rdy, exp_rdy);
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      check_eq("rsp_rdt", obs_rdt[rsp_q[0].own], rsp_q[0].rdt);
      check_eq("rsp_err", obs_err[rsp_q[0].own], rsp_q[0].err);
      void'(rsp_q.pop_front());
    end
    if (trn) begin
      rsp_q.push_back('{cyc: cyc + int'(DLY), own: g, rdt: $urandom, err: 1'($urandom)});
      m_ptr   = (g + 1) % IFN;
      m_owner = (LckEn && drv_lck[g]) ? g : -1;
    end else if (v) begin
      m_owner = g;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    if (trn) drv_vld[g] = 1'b0;
    for (int i = 0; i < int'(IFN); i++) begin
      if (!drv_vld[i] && ($urandom_range(99) < req_pct)) raise_req(i);
    end
    man_rdy = ($urandom_range(99) < rdy_pct);
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      man_rdt = rsp_q[0].rdt;
      man_err = rsp_q[0].err;
    end else begin
      man_rdt = $urandom;
      man_err = 1'b0;
    end
  endtask

  initial begin
    drv_vld = '0;
    drv_lck = '0;
    drv_wen = '0;
    for (int i = 0; i < int'(IFN); i++) begin
      drv_adr[i] = '0;
      drv_byt[i] = '0;
      drv_wdt[i] = '0;
    end
    man_rdy = 1'b0;
    man_rdt = '0;
    man_err = 1'b0;

    // Requests presented during reset must not leak through.
    repeat (2) @(posedge clk_i);
    #1;
    raise_req(1);
    man_rdy = 1'b1;
    @(negedge clk_i);
    check_eq("rst_gnt", gnt_o, 0);
    check_eq("rst_man_vld", man_if.vld, 0);
    check_eq("rst_sub_rdy", obs_rdy, 0);
    @(posedge clk_i);
    #1;
    drv_vld = '0;
    man_rdy = 1'b0;
    rst_ni  = 1'b1;

    repeat (60) run_cycle(100, 100);
    repeat (250) run_cycle(60, 50);
    repeat (200) run_cycle(25, 80);

    // Stall a granted request, then reset asynchronously while frozen.
    man_rdy = 1'b0;
    if (!drv_vld[1]) raise_req(1);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("arst_gnt", gnt_o, 0);
    check_eq("arst_man_vld", man_if.vld, 0);
    check_eq("arst_sub_rdy", obs_rdy, 0);
    drv_vld = '0;
    raise_req(1);
    man_rdy = 1'b1;
    m_ptr   = 0;
    m_owner = -1;
    rsp_q.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (60) run_cycle(50, 70);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
